// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load/store funct3 codes, MEM stage state,
// and lane helpers for the data-memory bus.
package cpu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_e;

  // Byte offset with the bits that are illegal for the size forced to 0.
  function automatic logic [1:0] align_off(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [1:0] r;
    case (f3[1:0])
      2'b00:   r = off;
      2'b01:   r = {off[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic r;
    case (f3[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = |off;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_be(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    logic [3:0] r;
    case (f3[1:0])
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = 4'b0011 << {off[1], 1'b0};
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_wdata(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load lane extraction from the read word plus sign/zero extension.
module load_align
  import cpu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    case (off)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    result = rdata;
    unique case (1'b1)
      (funct3 == LB):  result = {{24{b[7]}}, b};
      (funct3 == LBU): result = {24'd0, b};
      (funct3 == LH):  result = {{16{h[15]}}, h};
      (funct3 == LHU): result = {16'd0, h};
      default:         result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one outstanding data-memory access, WB register.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module mem_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        mem_ready,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        wb_misalign
);

  mem_state_e state, state_nxt;

  logic        accept;
  logic        is_mem;
  logic        mis;
  logic        done;
  logic        killed;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic        st_q;
  logic [31:0] ld_data;

  assign accept = ex_valid & mem_ready & ~flush;
  assign is_mem = ex_mem_read | ex_mem_write;
  assign done   = (state == WAIT) & dmem_ack;

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = is_mem & misaligned(ex_funct3, ex_result[1:0]);
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mem && !mis) state_nxt = WAIT;
      WAIT:    if (dmem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_ready = (state == IDLE);
    dmem_req  = (state == WAIT);
  end

  load_align u_align (
    .rdata  (dmem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .result (ld_data)
  );

  // Bus fields only load on accept, so they stay put until the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      st_q       <= 1'b0;
      killed     <= 1'b0;
    end else if (accept && is_mem && !mis) begin
      dmem_we    <= ex_mem_write;
      dmem_addr  <= {ex_result[31:2], 2'b00};
      dmem_be    <= lane_be(ex_funct3, ex_result[1:0]);
      dmem_wdata <= lane_wdata(ex_funct3, ex_store_data);
      off_q      <= align_off(ex_funct3, ex_result[1:0]);
      f3_q       <= ex_funct3;
      rd_q       <= ex_rd;
      rw_q       <= ex_reg_write;
      st_q       <= ex_mem_write;
      killed     <= 1'b0;
    end else if (state == WAIT && flush) begin
      killed     <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid     <= 1'b0;
      wb_result    <= '0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_misalign  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (done) begin
        wb_valid     <= ~(killed | flush);
        wb_result    <= st_q ? 32'd0 : ld_data;
        wb_rd        <= rd_q;
        wb_reg_write <= rw_q & ~st_q;
        wb_misalign  <= 1'b0;
      end else if (accept && (!is_mem || mis)) begin
        wb_valid     <= 1'b1;
        wb_result    <= ex_result;
        wb_rd        <= ex_rd;
        wb_reg_write <= ex_reg_write & ~mis;
        wb_misalign  <= mis;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized bench for mem_stage against a byte-level behavioural model.
module tb_mem_stage;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [31:0] ex_result;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        mem_ready;
  logic        flush;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic [31:0] wb_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        wb_misalign;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_ready     (mem_ready),
    .flush         (flush),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_ack      (dmem_ack),
    .dmem_rdata    (dmem_rdata),
    .wb_valid      (wb_valid),
    .wb_result     (wb_result),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_misalign   (wb_misalign)
  );

  int checks = 0;
  int errors = 0;

  bit          busy, killed;
  logic [31:0] p_addr;
  logic [2:0]  p_f3;
  logic [4:0]  p_rd;
  bit          p_rw, p_st;

  bit          e_valid, e_rw, e_mis, e_req, e_we, e_chk_res;
  logic [31:0] e_res, e_addr, e_wdata;
  logic [4:0]  e_rd;
  logic [3:0]  e_be;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] rdw,
                                             input logic [31:0] a,
                                             input logic [2:0]  f3);
    int n;
    int o;
    longint v;
    n = nbytes(f3);
    o = int'(a & 3);
    o = o - o % n;
    v = 0;
    for (int k = 0; k < n; k++)
      v = v | (longint'((rdw >> (8 * (o + k))) & 32'hFF) << (8 * k));
    if (f3[2] == 1'b0 && n < 4 && v[8*n-1])
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic model_eval;
    int n;
    int o;
    e_valid = 1'b0;
    if (!busy) begin
      if (ex_valid && !flush) begin
        if (ex_mem_read || ex_mem_write) begin
          n = nbytes(ex_funct3);
          o = int'(ex_result & 3);
          if (TRAP && (o % n) != 0) begin
            e_valid = 1'b1; e_mis = 1'b1; e_rw = 1'b0;
            e_rd = ex_rd; e_chk_res = 1'b0;
          end else begin
            busy = 1'b1; killed = 1'b0;
            p_addr = ex_result; p_f3 = ex_funct3; p_rd = ex_rd;
            p_rw = ex_reg_write; p_st = ex_mem_write;
            e_req = 1'b1; e_addr = ex_result & ~32'd3; e_we = ex_mem_write;
            o = o - o % n;
            e_be = '0;
            e_wdata = '0;
            for (int i = o; i < o + n; i++) e_be[i] = 1'b1;
            for (int i = 0; i < 4; i++)
              e_wdata[8*i +: 8] = ex_store_data[8*(i%n) +: 8];
          end
        end else begin
          e_valid = 1'b1; e_res = ex_result; e_rd = ex_rd;
          e_rw = ex_reg_write; e_mis = 1'b0; e_chk_res = 1'b1;
        end
      end
    end else begin
      if (flush) killed = 1'b1;
      if (dmem_ack) begin
        busy = 1'b0; e_req = 1'b0; e_valid = !killed;
        e_rd = p_rd; e_rw = p_rw && !p_st; e_mis = 1'b0;
        e_chk_res = !p_st;
        e_res = load_value(dmem_rdata, p_addr, p_f3);
      end
    end
  endtask

  task automatic compare;
    chk("wb_valid", wb_valid, e_valid);
    if (e_valid && wb_valid) begin
      chk("wb_rd", wb_rd, e_rd);
      chk("wb_reg_write", wb_reg_write, e_rw);
      chk("wb_misalign", wb_misalign, e_mis);
      if (e_chk_res) chk("wb_result", wb_result, e_res);
    end
    chk("dmem_req", dmem_req, e_req);
    if (e_req) begin
      chk("dmem_addr", dmem_addr, e_addr);
      chk("dmem_we", dmem_we, e_we);
      chk("dmem_be", dmem_be, e_be);
      if (e_we) chk("dmem_wdata", dmem_wdata, e_wdata);
    end
  endtask

  task automatic tick;
    chk("mem_ready", mem_ready, !busy);
    model_eval();
    @(posedge clk);
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic set_ex(input logic [31:0] res, input logic [31:0] sd,
                        input logic [4:0] rd, input logic mr,
                        input logic mw, input logic [2:0] f3,
                        input logic rw);
    ex_valid = 1'b1; ex_result = res; ex_store_data = sd; ex_rd = rd;
    ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3;
    ex_reg_write = rw;
  endtask

  task automatic clear_ex;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rw", wb_reg_write, 0);
    chk("rst_wb_mis", wb_misalign, 0);
    chk("rst_wb_result", wb_result, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_ready", mem_ready, 1);
    busy = 1'b0; e_req = 1'b0; e_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  int cnt;
  int lat;
  logic [2:0] ld_f3 [5];
  logic [2:0] st_f3 [3];

  initial begin
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
    ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    st_f3[0] = 3'b000; st_f3[1] = 3'b001; st_f3[2] = 3'b010;
    reset = 1'b1;
    ex_result = '0; ex_store_data = '0; ex_funct3 = '0; ex_rd = '0;
    ex_reg_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
    clear_ex();
    @(negedge clk);
    do_reset();

    // pass-through
    set_ex(32'h0000_1234, 0, 5'd5, 0, 0, 3'b000, 1);
    tick();
    clear_ex();
    chk("pt_valid", wb_valid, 1);
    chk("pt_result", wb_result, 32'h0000_1234);
    chk("pt_rd", wb_rd, 5);
    tick();

    // LB with three wait cycles
    set_ex(32'h103, 0, 5'd7, 1, 0, 3'b000, 1);
    dmem_rdata = 32'h80FF_0000;
    tick();
    clear_ex();
    cnt = 0;
    if (dmem_req && dmem_addr == 32'h100) cnt++;
    repeat (3) begin
      tick();
      if (dmem_req && dmem_addr == 32'h100) cnt++;
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("lb_hold", cnt, 4);
    chk("lb_valid", wb_valid, 1);
    chk("lb_result", wb_result, 32'hFFFF_FF80);

    // SH with immediate ack
    set_ex(32'h202, 32'h0000_ABCD, 5'd3, 0, 1, 3'b001, 1);
    tick();
    clear_ex();
    chk("sh_be", dmem_be, 4'b1100);
    chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
    chk("sh_we", dmem_we, 1);
    lat = 1;
    dmem_ack = 1'b1;
    while (!wb_valid && lat < 10) begin
      tick();
      lat++;
    end
    dmem_ack = 1'b0;
    chk("sh_lat", lat, 2);
    chk("sh_rw", wb_reg_write, 0);

    // flush in WAIT
    set_ex(32'h300, 0, 5'd9, 1, 0, 3'b010, 1);
    tick();
    clear_ex();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    chk("fl_valid", wb_valid, 0);
    chk("fl_ready", mem_ready, 1);

    // flush in IDLE
    set_ex(32'h55, 0, 5'd1, 0, 0, 3'b000, 1);
    flush = 1'b1;
    tick();
    clear_ex();
    chk("fi_valid", wb_valid, 0);

    // misaligned LW
    set_ex(32'h102, 0, 5'd4, 1, 0, 3'b010, 1);
    dmem_rdata = 32'h1122_3344;
    tick();
    clear_ex();
    if (TRAP) begin
      chk("mis_flag", wb_misalign, 1);
      chk("mis_req", dmem_req, 0);
    end else begin
      chk("mis_addr", dmem_addr, 32'h100);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("mis_result", wb_result, 32'h1122_3344);
    end

    // reset in WAIT
    set_ex(32'h400, 0, 5'd2, 1, 0, 3'b010, 1);
    tick();
    clear_ex();
    tick();
    do_reset();
    tick();
    chk("rw_valid", wb_valid, 0);

    // randomized traffic
    repeat (3000) begin
      ex_valid = ($urandom_range(0, 9) < 7);
      ex_result = $urandom;
      ex_store_data = $urandom;
      ex_rd = 5'($urandom);
      ex_reg_write = 1'($urandom);
      case ($urandom_range(0, 3))
        0: begin ex_mem_read = 0; ex_mem_write = 0;
                 ex_funct3 = 3'($urandom); end
        1: begin ex_mem_read = 1; ex_mem_write = 0;
                 ex_funct3 = ld_f3[$urandom_range(0, 4)]; end
        2: begin ex_mem_read = 0; ex_mem_write = 1;
                 ex_funct3 = st_f3[$urandom_range(0, 2)]; end
        default: begin ex_mem_read = 1; ex_mem_write = 1;
                 ex_funct3 = st_f3[$urandom_range(0, 2)]; end
      endcase
      flush = ($urandom_range(0, 9) == 0);
      dmem_rdata = $urandom;
      dmem_ack = busy && ($urandom_range(0, 2) == 0);
      tick();
    end

    clear_ex();
    cnt = 0;
    while (busy && cnt < 100) begin
      dmem_ack = 1'b1;
      tick();
      cnt++;
    end
    dmem_ack = 1'b0;
    chk("drain", busy, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-003 SHALL have the EX-side inputs:
- ex_valid, 1 bit.
- ex_result, 32 bits: ALU result, also the access address.
- ex_store_data, 32 bits.
- ex_mem_read, 1 bit.
- ex_mem_write, 1 bit.
- ex_funct3, 3 bits.
- ex_rd, 5 bits.
- ex_reg_write, 1 bit.
REQ-004 SHALL have port mem_ready, output, 1 bit: the stage accepts the EX instruction this cycle.
REQ-005 SHALL have port flush, input, 1 bit: kill the instruction being accepted or in flight.
REQ-006 SHALL have the data-memory bus outputs:
- dmem_req, 1 bit.
- dmem_we, 1 bit.
- dmem_addr, 32 bits, word-aligned.
- dmem_be, 4 bits.
- dmem_wdata, 32 bits.
REQ-007 SHALL have the data-memory bus inputs dmem_ack (1 bit) and dmem_rdata (32 bits).
REQ-008 SHALL have the WB-side outputs:
- wb_valid, 1 bit.
- wb_result, 32 bits.
- wb_rd, 5 bits.
- wb_reg_write, 1 bit.
- wb_misalign, 1 bit.

Function
REQ-009 SHALL accept an instruction on any edge where ex_valid=1, mem_ready=1 and flush=0; mem_ready=1 exactly when state=IDLE.
REQ-010 SHALL have two states:
- IDLE: accept allowed.
- WAIT: bus transaction outstanding.
REQ-011 SHALL pass a non-memory instruction through with 1-cycle latency: on the accept edge, register wb_result=ex_result, wb_rd, wb_reg_write, wb_valid=1; state stays IDLE.
REQ-012 SHALL, on accepting a load or store, enter WAIT and drive the bus from the next cycle:
- dmem_req=1.
- dmem_addr={ex_result[31:2],2'b00}.
- dmem_we=ex_mem_write.
- dmem_be and dmem_wdata replicated and lane-shifted per funct3 (SB/SH/SW).
REQ-013 SHALL hold every dmem_* output stable while dmem_req=1 and dmem_ack=0.
REQ-014 SHALL, on the edge where dmem_req=1 and dmem_ack=1:
- drop dmem_req;
- return to IDLE;
- register wb_valid=1 with, for loads, the byte/half/word of dmem_rdata selected by addr[1:0];
- sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-015 SHALL give a store wb_valid=1 with wb_reg_write=0 on ack.
REQ-016 SHALL have minimum load/store latency from accept edge to wb_valid of 2 cycles (ack in the first req cycle); there is no upper bound.
REQ-017 SHALL keep wb_valid high for exactly one cycle per completed instruction; wb_valid=0 otherwise.
REQ-018 SHALL, when flush=1 in IDLE, accept nothing.
REQ-019 SHALL, when flush=1 in WAIT, not abort the bus transaction; it completes normally but its wb_valid is suppressed. This holds also when flush and ack coincide.
REQ-020 SHALL treat ex_mem_read=ex_mem_write=1 as a store.

Reset
REQ-021 SHALL, on reset assertion, immediately (asynchronously) set:
- state=IDLE;
- dmem_req=0, dmem_we=0, dmem_be=0;
- wb_valid=0, wb_reg_write=0, wb_misalign=0;
- dmem_addr, dmem_wdata, wb_result, wb_rd=0.
REQ-022 SHALL, on reset mid-transaction, abandon the transaction with no WB output; mem_ready=1 from the first cycle after release.

Configuration
REQ-023 SHALL, when macro MEM_MISALIGN_TRAP_EN is defined, complete a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 in 1 cycle with:
- no dmem_req;
- wb_valid=1, wb_misalign=1, wb_reg_write=0.
REQ-024 SHALL, without MEM_MISALIGN_TRAP_EN, treat offending low address bits as zero for that access size; wb_misalign is then tied 0.

Structure
REQ-025 SHALL take from the shared cpu_pkg: the funct3 load/store encodings (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum (IDLE, WAIT).
REQ-026 SHALL place lane extraction and sign/zero extension in one combinational sub-module, load_align.

Verification
REQ-027 SHALL cover pass-through: accept ex_result=0x0000_1234, rd=5, non-mem -> next cycle wb_valid=1, wb_result=0x0000_1234, wb_rd=5, mem_ready never low.
REQ-028 SHALL cover LB: ex_result=0x103, dmem_rdata=0x80FF_0000, ack after 3 wait cycles -> dmem_addr=0x100 held 4 cycles, wb_result=0xFFFF_FF80.
REQ-029 SHALL cover SH: ex_result=0x202, store_data=0x0000_ABCD, immediate ack -> dmem_be=4'b1100, dmem_wdata=0xABCD_ABCD, dmem_we=1, wb_reg_write=0, latency 2.
REQ-030 SHALL cover flush: flush=1 in WAIT, ack 2 cycles later -> bus completes, no wb_valid, then mem_ready=1.
REQ-031 SHALL cover misalign: LW at 0x102 -> with MEM_MISALIGN_TRAP_EN, wb_misalign=1 and no dmem_req; without it, dmem_addr=0x100 and a normal load.
REQ-032 SHALL cover reset: reset asserted in WAIT -> dmem_req=0 in the same cycle, no wb_valid, mem_ready=1 after release.
